// File: rtl/sccomp_dataflow.sv
// Single-cycle MIPS-subset system: instruction ROM, data RAM and the CPU core.
// Register file storage sits at id_inst.cpu_ref.array_reg for debug dumps.

// 32 x 32-bit register file: two combinational reads, one write port, $0 hardwired to zero.
module sccomp_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1_c,
  output logic [31:0] rdata2_c,
  output logic [31:0] r16
);
  logic [31:0] array_reg [0:31];

  // Reset clears every register; otherwise commit the write unless it targets $0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) array_reg[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      array_reg[waddr] <= wdata;
    end
  end

  assign rdata1_c = (raddr1 == 5'd0) ? 32'h0 : array_reg[raddr1];
  assign rdata2_c = (raddr2 == 5'd0) ? 32'h0 : array_reg[raddr2];
  assign r16      = array_reg[16];
endmodule

// Core: decode, ALU, next-PC selection and register write-back.
module sccomp_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_stall,
  input  logic [31:0] inst,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dmem_addr_c,
  output logic [31:0] dmem_wdata_c,
  output logic        dmem_we_c,
  output logic [31:0] reg_16
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d, OP_XORI = 6'h0e, OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2b;
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR  = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;

  logic [31:0] pc_q, pc_d;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
  logic [31:0] pc_plus4, branch_tgt, jump_tgt, pc_next;
  logic        rf_we_c, mem_we_c;
  logic [4:0]  rf_waddr_c;
  logic [31:0] rf_wdata_c;

  assign op         = inst[31:26];
  assign rs         = inst[25:21];
  assign rt         = inst[20:16];
  assign rd         = inst[15:11];
  assign shamt      = inst[10:6];
  assign funct      = inst[5:0];
  assign imm_sext   = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext   = {16'h0, inst[15:0]};
  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], inst[25:0], 2'b00};

  sccomp_regfile cpu_ref (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we_c && !cpu_stall),
    .waddr    (rf_waddr_c),
    .wdata    (rf_wdata_c),
    .raddr1   (rs),
    .raddr2   (rt),
    .rdata1_c (rs_val),
    .rdata2_c (rt_val),
    .r16      (reg_16)
  );

  // Decode and execute: write-back value, memory write request and next PC.
  always_comb begin
    rf_we_c    = 1'b0;
    rf_waddr_c = rt;
    rf_wdata_c = 32'h0;
    mem_we_c   = 1'b0;
    pc_next    = pc_plus4;
    case (op)
      OP_RTYPE: begin
        rf_we_c    = 1'b1;
        rf_waddr_c = rd;
        case (funct)
          F_ADDU: rf_wdata_c = rs_val + rt_val;
          F_SUBU: rf_wdata_c = rs_val - rt_val;
          F_AND:  rf_wdata_c = rs_val & rt_val;
          F_OR:   rf_wdata_c = rs_val | rt_val;
          F_XOR:  rf_wdata_c = rs_val ^ rt_val;
          F_NOR:  rf_wdata_c = ~(rs_val | rt_val);
          F_SLT:  rf_wdata_c = {31'h0, $signed(rs_val) < $signed(rt_val)};
          F_SLTU: rf_wdata_c = {31'h0, rs_val < rt_val};
          F_SLL:  rf_wdata_c = rt_val << shamt;
          F_SRL:  rf_wdata_c = rt_val >> shamt;
          F_SRA:  rf_wdata_c = 32'($signed(rt_val) >>> shamt);
          F_JR: begin
            rf_we_c = 1'b0;
            pc_next = rs_val;
          end
          default: rf_we_c = 1'b0;
        endcase
      end
      OP_ADDIU: begin rf_we_c = 1'b1; rf_wdata_c = rs_val + imm_sext; end
      OP_SLTI:  begin rf_we_c = 1'b1; rf_wdata_c = {31'h0, $signed(rs_val) < $signed(imm_sext)}; end
      OP_SLTIU: begin rf_we_c = 1'b1; rf_wdata_c = {31'h0, rs_val < imm_sext}; end
      OP_ANDI:  begin rf_we_c = 1'b1; rf_wdata_c = rs_val & imm_zext; end
      OP_ORI:   begin rf_we_c = 1'b1; rf_wdata_c = rs_val | imm_zext; end
      OP_XORI:  begin rf_we_c = 1'b1; rf_wdata_c = rs_val ^ imm_zext; end
      OP_LUI:   begin rf_we_c = 1'b1; rf_wdata_c = {inst[15:0], 16'h0}; end
      OP_LW:    begin rf_we_c = 1'b1; rf_wdata_c = dmem_rdata; end
      OP_SW:    mem_we_c = 1'b1;
      OP_BEQ:   if (rs_val == rt_val) pc_next = branch_tgt;
      OP_BNE:   if (rs_val != rt_val) pc_next = branch_tgt;
      OP_J:     pc_next = jump_tgt;
      OP_JAL: begin
        rf_we_c    = 1'b1;
        rf_waddr_c = 5'd31;
        rf_wdata_c = pc_plus4;
        pc_next    = jump_tgt;
      end
      default: ;
    endcase
    pc_d = cpu_stall ? pc_q : pc_next;
  end

  // PC register; reset wins over stall.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc           = pc_q;
  assign dmem_addr_c  = rs_val + imm_sext;
  assign dmem_wdata_c = rt_val;
  assign dmem_we_c    = mem_we_c && !cpu_stall && !reset;
endmodule

// System top: ROM fetch, word-addressed data RAM, CPU core.
module sccomp_dataflow #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter string       IMEM_INIT  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_stall,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] reg_16
);
  localparam int unsigned IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [31:0]    rom [IMEM_DEPTH];
  logic [31:0]    ram [DMEM_DEPTH];
  logic [IAW-1:0] imem_idx;
  logic [DAW-1:0] dmem_idx;
  logic [31:0]    dmem_addr, dmem_wdata, dmem_rdata;
  logic           dmem_we;
  logic [3:0]     unused_addr_bits;

  assign imem_idx = IAW'(((pc - RESET_PC) >> 2) % 32'(IMEM_DEPTH));
  assign inst     = rom[imem_idx];

  // Only addr[11:2] selects the word; the rest of the address wraps away.
  assign dmem_idx         = DAW'(32'(dmem_addr[11:2]) % 32'(DMEM_DEPTH));
  assign dmem_rdata       = ram[dmem_idx];
  assign unused_addr_bits = {^dmem_addr[31:12], dmem_addr[1:0], 1'b0};

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (dmem_we) ram[dmem_idx] <= dmem_wdata;
  end

  sccomp_cpu #(.RESET_PC(RESET_PC)) id_inst (
    .clk          (clk),
    .reset        (reset),
    .cpu_stall    (cpu_stall),
    .inst         (inst),
    .dmem_rdata   (dmem_rdata),
    .pc           (pc),
    .dmem_addr_c  (dmem_addr),
    .dmem_wdata_c (dmem_wdata),
    .dmem_we_c    (dmem_we),
    .reg_16       (reg_16)
  );
endmodule

// File: tb/tb_sccomp_dataflow.sv
// Bench for sccomp_dataflow: runs a small hand-assembled program and checks the PC
// trace through a queue scoreboard, plus register/RAM state at key points.
module tb_sccomp_dataflow;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          NPROG  = 18;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_stall = 1'b0;
  logic [31:0] pc, inst, reg_16;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc_q [$];
  logic [31:0] prog [NPROG];
  logic [31:0] exp_regs [32];

  always #5 clk = ~clk;

  sccomp_dataflow #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_stall (cpu_stall),
    .pc        (pc),
    .inst      (inst),
    .reg_16    (reg_16)
  );

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - RST_PC) >> 2;
    if (idx < NPROG) return prog[idx];
    return 32'h0;
  endfunction

  // Pop n expected PCs, one per clock, comparing pc and the fetched word.
  task automatic consume(input int n, input string tag);
    logic [31:0] e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_pc_q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard empty at step %0d (pc=%h)", tag, k, pc);
      end else begin
        e = exp_pc_q.pop_front();
        if (pc !== e) begin
          errors++;
          $display("FAIL %s pc step %0d: got %h expected %h", tag, k, pc, e);
        end
        checks++;
        if (inst !== exp_inst(e)) begin
          errors++;
          $display("FAIL %s inst step %0d: got %h expected %h", tag, k, inst, exp_inst(e));
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pc !== RST_PC) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC);
    end
    checks++;
    if (inst !== 32'h3C011234) begin
      errors++; $display("FAIL reset_inst: got %h expected %h", inst, 32'h3C011234);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.id_inst.cpu_ref.array_reg[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected 0", i, dut.id_inst.cpu_ref.array_reg[i]);
      end
    end
    reset = 1'b0;
  endtask

  // ALU, immediates, beq/bne, jal/jr up to the sw.
  task automatic test_alu_branch;
    logic [31:0] trace [11] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20,
                                 32'h40, 32'h44, 32'h24, 32'h28, 32'h2C};
    for (int i = 0; i < 11; i++) exp_pc_q.push_back(RST_PC + trace[i]);
    consume(11, "alu_branch");
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.id_inst.cpu_ref.array_reg[i] !== exp_regs[i]) begin
        errors++;
        $display("FAIL regs_pre_sw r%0d: got %h expected %h", i, dut.id_inst.cpu_ref.array_reg[i], exp_regs[i]);
      end
    end
  endtask

  // Stall across the sw: nothing may change.
  task automatic test_stall;
    cpu_stall = 1'b1;
    for (int k = 0; k < 5; k++) exp_pc_q.push_back(RST_PC + 32'h2C);
    for (int k = 0; k < 5; k++) begin
      consume(1, "stall");
      checks++;
      if (dut.ram[2] === 32'h12345678) begin
        errors++; $display("FAIL stall_ram: got %h, store must not commit", dut.ram[2]);
      end
      checks++;
      if (dut.id_inst.cpu_ref.array_reg[1] !== 32'h12345678 || reg_16 !== 32'h0) begin
        errors++;
        $display("FAIL stall_regs: r1=%h r16=%h expected 12345678 and 0", dut.id_inst.cpu_ref.array_reg[1], reg_16);
      end
    end
    cpu_stall = 1'b0;
  endtask

  // Resume: sw, lw, $0 write, unknown opcode, self-jump.
  task automatic test_back_to_back;
    logic [31:0] trace [5] = '{32'h30, 32'h34, 32'h38, 32'h3C, 32'h3C};
    for (int i = 0; i < 5; i++) exp_pc_q.push_back(RST_PC + trace[i]);
    consume(5, "resume");
    exp_regs[16] = 32'h12345678;
    checks++;
    if (reg_16 !== 32'h12345678) begin
      errors++; $display("FAIL reg_16_lw: got %h expected %h", reg_16, 32'h12345678);
    end
    checks++;
    if (dut.ram[2] !== 32'h12345678) begin
      errors++; $display("FAIL ram_sw: got %h expected %h", dut.ram[2], 32'h12345678);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.id_inst.cpu_ref.array_reg[i] !== exp_regs[i]) begin
        errors++;
        $display("FAIL regs_final r%0d: got %h expected %h", i, dut.id_inst.cpu_ref.array_reg[i], exp_regs[i]);
      end
    end
  endtask

  // Reset mid-run, restart, then a reset that aborts a pending write.
  task automatic test_reset_mid;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pc !== RST_PC) begin
      errors++; $display("FAIL midreset_pc: got %h expected %h", pc, RST_PC);
    end
    checks++;
    if (reg_16 !== 32'h0) begin
      errors++; $display("FAIL midreset_r16: got %h expected 0", reg_16);
    end
    checks++;
    if (dut.ram[2] !== 32'h12345678) begin
      errors++; $display("FAIL midreset_ram: got %h expected %h", dut.ram[2], 32'h12345678);
    end
    reset = 1'b0;
    exp_pc_q.push_back(RST_PC + 32'h04);
    exp_pc_q.push_back(RST_PC + 32'h08);
    consume(2, "restart");
    checks++;
    if (dut.id_inst.cpu_ref.array_reg[1] !== 32'h12345678) begin
      errors++; $display("FAIL restart_r1: got %h expected %h", dut.id_inst.cpu_ref.array_reg[1], 32'h12345678);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut.id_inst.cpu_ref.array_reg[2] !== 32'h0 || pc !== RST_PC) begin
      errors++;
      $display("FAIL abort_write: r2=%h pc=%h expected 0 and %h", dut.id_inst.cpu_ref.array_reg[2], pc, RST_PC);
    end
    reset = 1'b0;
  endtask

  initial begin
    prog = '{32'h3C011234, 32'h34215678, 32'h2402FFFF, 32'h0002182B,
             32'h10000002, 32'h24100BAD, 32'h24100BAD, 32'h14000003,
             32'h0C100010, 32'h0002202A, 32'h00022903, 32'hAC010008,
             32'h8C100008, 32'h24000005, 32'hFFFFFFFF, 32'h0810000F,
             32'h24060007, 32'h03E00008};
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    exp_regs[1]  = 32'h12345678;
    exp_regs[2]  = 32'hFFFFFFFF;
    exp_regs[3]  = 32'h00000001;
    exp_regs[4]  = 32'h00000000;
    exp_regs[5]  = 32'hFFFFFFFF;
    exp_regs[6]  = 32'h00000007;
    exp_regs[31] = 32'h00400024;
    for (int i = 0; i < NPROG; i++) dut.rom[i] = prog[i];

    test_reset();
    test_alu_branch();
    test_stall();
    test_back_to_back();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if the run ever overruns its cycle budget.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
